// File: rtl/regfile_multiport.sv
// ---------------------------------------------------------------------------
// regfile_multiport
//
// Purpose:
//   Parametrised DEPTH x WIDTH register file with one write port and NUM_READ
//   independent registered read ports (latency 1). It sits between the decode
//   stage (reads) and writeback (write). Optional features are a hardwired
//   zero register and same-cycle write-to-read forwarding.
//
// Ports:
//   clk       in   1                rising-edge clock
//   reset     in   1                asynchronous, active-low reset
//   wr_en     in   1                write strobe
//   wr_addr   in   ADDR_W           write index
//   wr_data   in   WIDTH            write data
//   rd_en     in   NUM_READ         per-port read request
//   rd_addr   in   NUM_READ*ADDR_W  port p address = [p*ADDR_W +: ADDR_W]
//   rd_data   out  NUM_READ*WIDTH   port p data    = [p*WIDTH +: WIDTH]
//   rd_valid  out  NUM_READ         port p data valid this cycle
// ---------------------------------------------------------------------------
module regfile_multiport #(
    parameter int WIDTH     = 64,
    parameter int DEPTH     = 32,
    parameter int NUM_READ  = 2,
    parameter int ADDR_W    = $clog2(DEPTH),
    parameter bit ZERO_EN   = 1'b1,
    parameter int ZERO_IDX  = DEPTH - 1,
    parameter bit BYPASS_EN = 1'b1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         wr_en,
    input  logic [ADDR_W-1:0]            wr_addr,
    input  logic [WIDTH-1:0]             wr_data,
    input  logic [NUM_READ-1:0]          rd_en,
    input  logic [NUM_READ*ADDR_W-1:0]   rd_addr,
    output logic [NUM_READ*WIDTH-1:0]    rd_data,
    output logic [NUM_READ-1:0]          rd_valid
);

    logic [WIDTH-1:0] mem  [DEPTH];
    logic [WIDTH-1:0] rd_q [NUM_READ];
    logic [WIDTH-1:0] rd_next [NUM_READ];
    logic             wr_ok;

    // Addresses at or above DEPTH exist whenever DEPTH is not a power of two.
    function automatic logic addr_in_range(input logic [ADDR_W-1:0] a);
        return (int'(a) < DEPTH);
    endfunction

    function automatic logic addr_is_zero(input logic [ADDR_W-1:0] a);
        return ZERO_EN && (int'(a) == ZERO_IDX);
    endfunction

    // A write only lands when it targets a real, non-hardwired register.
    always_comb begin
        wr_ok = wr_en && addr_in_range(wr_addr) && !addr_is_zero(wr_addr);
    end

    // Storage update. The address is compared against every index rather than
    // used as an array subscript, so an out-of-range address touches nothing.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wr_ok && (wr_addr == ADDR_W'(i))) begin
                    mem[i] <= wr_data;
                end
            end
        end
    end

    // Per-port read value. Out-of-range and zero-register reads return 0;
    // a forwarded write wins over the stored entry; otherwise a DEPTH:1
    // one-hot select of the pre-edge contents.
    always_comb begin
        logic [ADDR_W-1:0] a;
        a = '0;
        for (int p = 0; p < NUM_READ; p++) begin
            rd_next[p] = '0;
            a = rd_addr[p*ADDR_W +: ADDR_W];
            if (addr_in_range(a) && !addr_is_zero(a)) begin
                if (BYPASS_EN && wr_ok && (wr_addr == a)) begin
                    rd_next[p] = wr_data;
                end else begin
                    for (int i = 0; i < DEPTH; i++) begin
                        if (a == ADDR_W'(i)) begin
                            rd_next[p] = mem[i];
                        end
                    end
                end
            end
        end
    end

    // Output registers: data only moves on a request, valid follows rd_en.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int p = 0; p < NUM_READ; p++) begin
                rd_q[p] <= '0;
            end
            rd_valid <= '0;
        end else begin
            for (int p = 0; p < NUM_READ; p++) begin
                if (rd_en[p]) begin
                    rd_q[p] <= rd_next[p];
                end
            end
            rd_valid <= rd_en;
        end
    end

    always_comb begin
        rd_data = '0;
        for (int p = 0; p < NUM_READ; p++) begin
            rd_data[p*WIDTH +: WIDTH] = rd_q[p];
        end
    end

endmodule

// File: tb/tb_regfile_multiport.sv
// ---------------------------------------------------------------------------
// tb_regfile_multiport
//
// Two register files share clock and reset:
//   dut_a : defaults (32 x 64, two read ports, bypass on, XZR = 31)
//   dut_b : DEPTH=24, three read ports, bypass off (zero register = 23)
// A directed vector table exercises dut_a, hand-written sequences cover
// reset, multi-port and non-power-of-two behaviour, and a random sweep
// compares both instances against an array-based reference model.
// ---------------------------------------------------------------------------
module tb_regfile_multiport;

    logic         clk;
    logic         reset;

    logic         a_wr_en;
    logic [4:0]   a_wr_addr;
    logic [63:0]  a_wr_data;
    logic [1:0]   a_rd_en;
    logic [9:0]   a_rd_addr;
    logic [127:0] a_rd_data;
    logic [1:0]   a_rd_valid;

    logic         b_wr_en;
    logic [4:0]   b_wr_addr;
    logic [63:0]  b_wr_data;
    logic [2:0]   b_rd_en;
    logic [14:0]  b_rd_addr;
    logic [191:0] b_rd_data;
    logic [2:0]   b_rd_valid;

    int checks = 0;
    int errors = 0;

    // Reference model: plain register contents plus the expected output
    // registers of every port, per instance (index 0 = dut_a, 1 = dut_b).
    logic [63:0] mdl   [2][32];
    logic [63:0] exp_d [2][3];
    logic        exp_v [2][3];
    int          dep   [2] = '{32, 24};
    bit          byp   [2] = '{1'b1, 1'b0};

    typedef struct packed {
        logic        we;
        logic [4:0]  wa;
        logic [63:0] wd;
        logic [1:0]  re;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [1:0]  ev;
        logic [63:0] ed0;
        logic [63:0] ed1;
    } vec_t;

    vec_t vecs [8];

    regfile_multiport dut_a (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (a_wr_en),
        .wr_addr  (a_wr_addr),
        .wr_data  (a_wr_data),
        .rd_en    (a_rd_en),
        .rd_addr  (a_rd_addr),
        .rd_data  (a_rd_data),
        .rd_valid (a_rd_valid)
    );

    regfile_multiport #(
        .DEPTH     (24),
        .NUM_READ  (3),
        .BYPASS_EN (1'b0)
    ) dut_b (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (b_wr_en),
        .wr_addr  (b_wr_addr),
        .wr_data  (b_wr_data),
        .rd_en    (b_rd_en),
        .rd_addr  (b_rd_addr),
        .rd_data  (b_rd_data),
        .rd_valid (b_rd_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Value a read of address a returns, straight from the register-file rules.
    function automatic logic [63:0] ref_read(input int k, input int a, input logic we,
                                             input int wa, input logic [63:0] wd);
        if (a >= dep[k] || a == dep[k] - 1) return 64'h0;
        if (byp[k] && we && wa == a) return wd;
        return mdl[k][a];
    endfunction

    task automatic ref_write(input int k, input logic we, input int wa, input logic [63:0] wd);
        if (we && wa < dep[k] && wa != dep[k] - 1) mdl[k][wa] = wd;
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 32; i++) mdl[k][i] = 64'h0;
            for (int p = 0; p < 3; p++) begin
                exp_d[k][p] = 64'h0;
                exp_v[k][p] = 1'b0;
            end
        end
    endtask

    task automatic idle_inputs();
        a_wr_en = 1'b0; a_wr_addr = '0; a_wr_data = '0; a_rd_en = '0; a_rd_addr = '0;
        b_wr_en = 1'b0; b_wr_addr = '0; b_wr_data = '0; b_rd_en = '0; b_rd_addr = '0;
    endtask

    // One clock edge with the currently driven inputs; the model is advanced
    // with the same inputs, then outputs are ready to sample 1ns after the edge.
    task automatic applyStimulus();
        @(posedge clk);
        for (int p = 0; p < 2; p++) begin
            exp_v[0][p] = a_rd_en[p];
            if (a_rd_en[p])
                exp_d[0][p] = ref_read(0, int'(a_rd_addr[p*5 +: 5]), a_wr_en, int'(a_wr_addr), a_wr_data);
        end
        for (int p = 0; p < 3; p++) begin
            exp_v[1][p] = b_rd_en[p];
            if (b_rd_en[p])
                exp_d[1][p] = ref_read(1, int'(b_rd_addr[p*5 +: 5]), b_wr_en, int'(b_wr_addr), b_wr_data);
        end
        ref_write(0, a_wr_en, int'(a_wr_addr), a_wr_data);
        ref_write(1, b_wr_en, int'(b_wr_addr), b_wr_data);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    task automatic check_model();
        for (int p = 0; p < 2; p++) begin
            checkOutput($sformatf("a_data%0d", p), a_rd_data[p*64 +: 64], exp_d[0][p]);
            checkOutput($sformatf("a_valid%0d", p), {63'h0, a_rd_valid[p]}, {63'h0, exp_v[0][p]});
        end
        for (int p = 0; p < 3; p++) begin
            checkOutput($sformatf("b_data%0d", p), b_rd_data[p*64 +: 64], exp_d[1][p]);
            checkOutput($sformatf("b_valid%0d", p), {63'h0, b_rd_valid[p]}, {63'h0, exp_v[1][p]});
        end
    endtask

    task automatic check_all_zero(input string tag);
        checkOutput({tag, " a_valid"}, {62'h0, a_rd_valid}, 64'h0);
        checkOutput({tag, " a_data0"}, a_rd_data[63:0], 64'h0);
        checkOutput({tag, " a_data1"}, a_rd_data[127:64], 64'h0);
        checkOutput({tag, " b_valid"}, {61'h0, b_rd_valid}, 64'h0);
        checkOutput({tag, " b_data"}, b_rd_data[63:0] | b_rd_data[127:64] | b_rd_data[191:128], 64'h0);
    endtask

    initial begin
        logic [63:0] want;

        // Directed vectors for dut_a, starting from a freshly reset file.
        vecs[0] = '{1'b1, 5'd5,  64'hDEAD_BEEF_0123_4567, 2'b00, 5'd0,  5'd0,  2'b00, 64'h0, 64'h0};
        vecs[1] = '{1'b0, 5'd0,  64'h0,                  2'b01, 5'd5,  5'd0,  2'b01, 64'hDEAD_BEEF_0123_4567, 64'h0};
        vecs[2] = '{1'b1, 5'd7,  64'h11,                 2'b10, 5'd0,  5'd7,  2'b10, 64'hDEAD_BEEF_0123_4567, 64'h11};
        vecs[3] = '{1'b1, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF, 2'b11, 5'd31, 5'd31, 2'b11, 64'h0, 64'h0};
        vecs[4] = '{1'b0, 5'd0,  64'h0,                  2'b11, 5'd31, 5'd31, 2'b11, 64'h0, 64'h0};
        vecs[5] = '{1'b0, 5'd0,  64'h0,                  2'b11, 5'd7,  5'd5,  2'b11, 64'h11, 64'hDEAD_BEEF_0123_4567};
        vecs[6] = '{1'b1, 5'd5,  64'h55,                 2'b11, 5'd5,  5'd5,  2'b11, 64'h55, 64'h55};
        vecs[7] = '{1'b0, 5'd0,  64'h0,                  2'b00, 5'd0,  5'd0,  2'b00, 64'h55, 64'h55};

        idle_inputs();
        model_reset();
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("initial reset");
        @(negedge clk);
        reset = 1'b1;

        $display("[TB] directed vector table on dut_a");
        for (int v = 0; v < 8; v++) begin
            idle_inputs();
            a_wr_en   = vecs[v].we;
            a_wr_addr = vecs[v].wa;
            a_wr_data = vecs[v].wd;
            a_rd_en   = vecs[v].re;
            a_rd_addr = {vecs[v].ra1, vecs[v].ra0};
            applyStimulus();
            checkOutput($sformatf("vec%0d valid", v), {62'h0, a_rd_valid}, {62'h0, vecs[v].ev});
            checkOutput($sformatf("vec%0d data0", v), a_rd_data[63:0], vecs[v].ed0);
            checkOutput($sformatf("vec%0d data1", v), a_rd_data[127:64], vecs[v].ed1);
        end

        $display("[TB] reset asserted mid-traffic");
        idle_inputs();
        a_rd_en = 2'b11; a_rd_addr = {5'd5, 5'd7};
        b_rd_en = 3'b111;
        applyStimulus();
        checkOutput("pre-reset a_valid", {62'h0, a_rd_valid}, 64'h3);
        #2;
        reset = 1'b0;
        #1;
        check_all_zero("async reset");
        model_reset();
        @(posedge clk);
        #1;
        check_all_zero("reset held");
        idle_inputs();
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 32; i++) begin
            a_rd_en = 2'b11;
            a_rd_addr = {5'(31 - i), 5'(i)};
            applyStimulus();
            checkOutput($sformatf("post-reset reg%0d valid", i), {62'h0, a_rd_valid}, 64'h3);
            checkOutput($sformatf("post-reset reg%0d data", i), a_rd_data[63:0] | a_rd_data[127:64], 64'h0);
        end

        $display("[TB] dut_b multi-port, no bypass, DEPTH=24");
        idle_inputs();
        b_wr_en = 1'b1; b_wr_addr = 5'd1; b_wr_data = 64'hA;
        applyStimulus();
        b_wr_addr = 5'd2; b_wr_data = 64'hB;
        applyStimulus();
        idle_inputs();
        b_rd_en = 3'b111; b_rd_addr = {5'd2, 5'd1, 5'd1};
        applyStimulus();
        checkOutput("mp valid", {61'h0, b_rd_valid}, 64'h7);
        checkOutput("mp data", b_rd_data[191:128] ^ {b_rd_data[127:64], 4'h0} ^ {b_rd_data[63:0], 8'h0}, 64'hB ^ 64'hA0 ^ 64'hA00);
        checkOutput("mp data0", b_rd_data[63:0], 64'hA);
        checkOutput("mp data2", b_rd_data[191:128], 64'hB);
        b_rd_en = 3'b010; b_rd_addr = {5'd0, 5'd0, 5'd0};
        applyStimulus();
        checkOutput("mp partial valid", {61'h0, b_rd_valid}, 64'h2);
        checkOutput("mp hold data0", b_rd_data[63:0], 64'hA);
        checkOutput("mp new data1", b_rd_data[127:64], 64'h0);
        checkOutput("mp hold data2", b_rd_data[191:128], 64'hB);
        b_wr_en = 1'b1; b_wr_addr = 5'd7; b_wr_data = 64'h11;
        b_rd_addr = {5'd0, 5'd7, 5'd0};
        applyStimulus();
        checkOutput("no-bypass old value", b_rd_data[127:64], 64'h0);
        b_wr_en = 1'b0;
        applyStimulus();
        checkOutput("no-bypass next cycle", b_rd_data[127:64], 64'h11);
        idle_inputs();
        b_wr_en = 1'b1; b_wr_addr = 5'd30; b_wr_data = 64'hFFFF_FFFF_FFFF_FFFF;
        applyStimulus();
        b_wr_addr = 5'd23;
        b_rd_en = 3'b111; b_rd_addr = {5'd23, 5'd23, 5'd23};
        applyStimulus();
        checkOutput("zero reg same-cycle", b_rd_data[63:0] | b_rd_data[127:64] | b_rd_data[191:128], 64'h0);
        b_wr_en = 1'b0;
        b_rd_addr = {5'd23, 5'd23, 5'd30};
        applyStimulus();
        checkOutput("out-of-range read", b_rd_data[63:0], 64'h0);
        checkOutput("zero reg read", b_rd_data[127:64] | b_rd_data[191:128], 64'h0);
        for (int i = 0; i < 24; i++) begin
            b_rd_en = 3'b001; b_rd_addr = {10'h0, 5'(i)};
            applyStimulus();
            want = (i == 1) ? 64'hA : (i == 2) ? 64'hB : (i == 7) ? 64'h11 : 64'h0;
            checkOutput($sformatf("b entry%0d", i), b_rd_data[63:0], want);
        end

        $display("[TB] random sweep against reference model");
        for (int n = 0; n < 400; n++) begin
            a_wr_en   = 1'($urandom);
            a_wr_addr = 5'($urandom);
            a_wr_data = {$urandom(), $urandom()};
            a_rd_en   = 2'($urandom);
            a_rd_addr = (n % 4 == 0) ? {2{a_wr_addr}} : 10'($urandom);
            b_wr_en   = 1'($urandom);
            b_wr_addr = 5'($urandom);
            b_wr_data = {$urandom(), $urandom()};
            b_rd_en   = 3'($urandom);
            b_rd_addr = (n % 4 == 1) ? {3{b_wr_addr}} : 15'($urandom);
            applyStimulus();
            check_model();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
